// File: rtl/proc_mem_arbiter_if.sv
// Memory message types plus the grouped core/memory stream bundle used by proc_mem_arbiter.
// The arbiter connects through the slave modport; the surrounding system drives the master side.
package mem_msgs_pkg;
  localparam logic [2:0] MEM_READ  = 3'd0;
  localparam logic [2:0] MEM_WRITE = 3'd1;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;
endpackage

interface proc_mem_arbiter_if;
  mem_msgs_pkg::mem_req_4B_t  imem_reqstream_msg;
  logic                       imem_reqstream_val;
  logic                       imem_reqstream_rdy;
  mem_msgs_pkg::mem_req_4B_t  dmem_reqstream_msg;
  logic                       dmem_reqstream_val;
  logic                       dmem_reqstream_rdy;
  mem_msgs_pkg::mem_req_4B_t  mem_reqstream_msg;
  logic                       mem_reqstream_val;
  logic                       mem_reqstream_rdy;
  mem_msgs_pkg::mem_resp_4B_t mem_respstream_msg;
  logic                       mem_respstream_val;
  logic                       mem_respstream_rdy;
  mem_msgs_pkg::mem_resp_4B_t imem_respstream_msg;
  logic                       imem_respstream_val;
  logic                       imem_respstream_rdy;
  mem_msgs_pkg::mem_resp_4B_t dmem_respstream_msg;
  logic                       dmem_respstream_val;
  logic                       dmem_respstream_rdy;

  modport slave (
    input  imem_reqstream_msg, imem_reqstream_val, output imem_reqstream_rdy,
    input  dmem_reqstream_msg, dmem_reqstream_val, output dmem_reqstream_rdy,
    output mem_reqstream_msg, mem_reqstream_val, input mem_reqstream_rdy,
    input  mem_respstream_msg, mem_respstream_val, output mem_respstream_rdy,
    output imem_respstream_msg, imem_respstream_val, input imem_respstream_rdy,
    output dmem_respstream_msg, dmem_respstream_val, input dmem_respstream_rdy
  );

  modport master (
    output imem_reqstream_msg, imem_reqstream_val, input imem_reqstream_rdy,
    output dmem_reqstream_msg, dmem_reqstream_val, input dmem_reqstream_rdy,
    input  mem_reqstream_msg, mem_reqstream_val, output mem_reqstream_rdy,
    output mem_respstream_msg, mem_respstream_val, input mem_respstream_rdy,
    input  imem_respstream_msg, imem_respstream_val, output imem_respstream_rdy,
    input  dmem_respstream_msg, dmem_respstream_val, output dmem_respstream_rdy
  );
endinterface

// File: rtl/proc_mem_arbiter.sv
// Round-robin merge of imem/dmem requests onto one memory port, with source tagging in
// opaque[7], response steering by that tag, and a bound on outstanding transactions.
module proc_mem_arbiter
  import mem_msgs_pkg::*;
#(
  parameter int unsigned p_max_inflight = 4
) (
  input  logic                clk,
  input  logic                reset,
  proc_mem_arbiter_if.slave   bus
);

  typedef enum logic {
    BUF_EMPTY,
    BUF_FULL
  } buf_state_t;

  buf_state_t  state, state_next;
  mem_req_4B_t buf_msg;
  mem_req_4B_t enq_msg;
  logic        prio;      // 0: imem wins a tie, 1: dmem wins a tie
  logic [3:0]  inflight;

  logic at_limit;
  logic mem_req_val;
  logic mem_req_xfer;
  logic can_accept;
  logic grant_imem;
  logic grant_dmem;
  logic enq;
  logic resp_sel;
  logic resp_rdy;
  logic resp_xfer;
  mem_resp_4B_t resp_fwd;

  always_comb begin
    at_limit     = (inflight == 4'(p_max_inflight));
    mem_req_val  = !reset && (state == BUF_FULL) && !at_limit;
    mem_req_xfer = mem_req_val && bus.mem_reqstream_rdy;
    // At the limit the buffer can neither drain nor take a new entry.
    can_accept   = !reset && !at_limit && ((state == BUF_EMPTY) || bus.mem_reqstream_rdy);

    grant_imem = bus.imem_reqstream_val && (!bus.dmem_reqstream_val || !prio);
    grant_dmem = bus.dmem_reqstream_val && (!bus.imem_reqstream_val || prio);
    enq        = can_accept && (grant_imem || grant_dmem);

    enq_msg           = grant_dmem ? bus.dmem_reqstream_msg : bus.imem_reqstream_msg;
    enq_msg.opaque[7] = grant_dmem;

    state_next = state;
    if (enq) begin
      state_next = BUF_FULL;
    end else if (mem_req_xfer) begin
      state_next = BUF_EMPTY;
    end
  end

  always_comb begin
    resp_sel           = bus.mem_respstream_msg.opaque[7];
    resp_fwd           = bus.mem_respstream_msg;
    resp_fwd.opaque[7] = 1'b0;
    resp_rdy           = !reset && (resp_sel ? bus.dmem_respstream_rdy : bus.imem_respstream_rdy);
    resp_xfer          = bus.mem_respstream_val && resp_rdy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= BUF_EMPTY;
      buf_msg <= '0;
      prio    <= 1'b0;
    end else begin
      state <= state_next;
      if (enq) begin
        buf_msg <= enq_msg;
        prio    <= grant_imem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      assert (!resp_xfer || inflight != '0)
        else $error("memory response with no outstanding request");
      if (mem_req_xfer && !resp_xfer) begin
        inflight <= inflight + 4'd1;
      end else if (resp_xfer && !mem_req_xfer && inflight != '0) begin
        inflight <= inflight - 4'd1;
      end
    end
  end

  assign bus.imem_reqstream_rdy  = can_accept && grant_imem;
  assign bus.dmem_reqstream_rdy  = can_accept && grant_dmem;
  assign bus.mem_reqstream_msg   = buf_msg;
  assign bus.mem_reqstream_val   = mem_req_val;
  assign bus.mem_respstream_rdy  = resp_rdy;
  assign bus.imem_respstream_msg = resp_fwd;
  assign bus.dmem_respstream_msg = resp_fwd;
  assign bus.imem_respstream_val = !reset && bus.mem_respstream_val && !resp_sel;
  assign bus.dmem_respstream_val = !reset && bus.mem_respstream_val && resp_sel;

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Directed bench for proc_mem_arbiter: one instance at the default inflight limit and one at 2.
module tb_proc_mem_arbiter;
  import mem_msgs_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  proc_mem_arbiter_if bus ();
  proc_mem_arbiter_if lim ();

  proc_mem_arbiter #(.p_max_inflight(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  proc_mem_arbiter #(.p_max_inflight(2)) dut_lim (.clk(clk), .reset(reset), .bus(lim));

  int checks = 0;
  int errors = 0;

  function automatic mem_req_4B_t mk_req(logic [2:0] t, logic [7:0] op, logic [31:0] a, logic [31:0] d);
    mem_req_4B_t m;
    m.type_ = t; m.opaque = op; m.addr = a; m.len = 2'd0; m.data = d;
    return m;
  endfunction

  function automatic mem_resp_4B_t mk_resp(logic [7:0] op, logic [31:0] d);
    mem_resp_4B_t m;
    m.type_ = MEM_READ; m.opaque = op; m.test = 2'd0; m.len = 2'd0; m.data = d;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.imem_reqstream_msg = '0;  bus.imem_reqstream_val = 1'b0;
    bus.dmem_reqstream_msg = '0;  bus.dmem_reqstream_val = 1'b0;
    bus.mem_reqstream_rdy  = 1'b0;
    bus.mem_respstream_msg = '0;  bus.mem_respstream_val = 1'b0;
    bus.imem_respstream_rdy = 1'b0; bus.dmem_respstream_rdy = 1'b0;
    lim.imem_reqstream_msg = '0;  lim.imem_reqstream_val = 1'b0;
    lim.dmem_reqstream_msg = '0;  lim.dmem_reqstream_val = 1'b0;
    lim.mem_reqstream_rdy  = 1'b0;
    lim.mem_respstream_msg = '0;  lim.mem_respstream_val = 1'b0;
    lim.imem_respstream_rdy = 1'b0; lim.dmem_respstream_rdy = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.imem_reqstream_val = 1'b1; bus.dmem_reqstream_val = 1'b1;
    bus.mem_reqstream_rdy = 1'b1;
    bus.mem_respstream_val = 1'b1; bus.mem_respstream_msg = mk_resp(8'h00, 32'h1);
    bus.imem_respstream_rdy = 1'b1; bus.dmem_respstream_rdy = 1'b1;
    tick();
    tick();
    checks++; if (bus.imem_reqstream_rdy !== 1'b0) begin errors++; $display("FAIL rst_imem_rdy: got %b expected 0", bus.imem_reqstream_rdy); end
    checks++; if (bus.dmem_reqstream_rdy !== 1'b0) begin errors++; $display("FAIL rst_dmem_rdy: got %b expected 0", bus.dmem_reqstream_rdy); end
    checks++; if (bus.mem_reqstream_val !== 1'b0) begin errors++; $display("FAIL rst_mem_val: got %b expected 0", bus.mem_reqstream_val); end
    checks++; if (bus.mem_respstream_rdy !== 1'b0) begin errors++; $display("FAIL rst_resp_rdy: got %b expected 0", bus.mem_respstream_rdy); end
    checks++; if (bus.imem_respstream_val !== 1'b0) begin errors++; $display("FAIL rst_imem_resp_val: got %b expected 0", bus.imem_respstream_val); end
    checks++; if (bus.dmem_respstream_val !== 1'b0) begin errors++; $display("FAIL rst_dmem_resp_val: got %b expected 0", bus.dmem_respstream_val); end
    idle();
    reset = 1'b0;
    #1;
    checks++; if (bus.mem_reqstream_val !== 1'b0) begin errors++; $display("FAIL post_rst_mem_val: got %b expected 0", bus.mem_reqstream_val); end
    tick();
    checks++; if (bus.mem_reqstream_val !== 1'b0) begin errors++; $display("FAIL post_rst_idle_mem_val: got %b expected 0", bus.mem_reqstream_val); end
  endtask

  task automatic test_imem_read();
    do_reset();
    bus.mem_reqstream_rdy = 1'b1;
    bus.imem_reqstream_val = 1'b1;
    bus.imem_reqstream_msg = mk_req(MEM_READ, 8'h00, 32'h200, 32'h0);
    #1;
    checks++; if (bus.imem_reqstream_rdy !== 1'b1) begin errors++; $display("FAIL ird_imem_rdy: got %b expected 1", bus.imem_reqstream_rdy); end
    checks++; if (bus.mem_reqstream_val !== 1'b0) begin errors++; $display("FAIL ird_mem_val_early: got %b expected 0", bus.mem_reqstream_val); end
    tick();
    bus.imem_reqstream_val = 1'b0;
    #1;
    checks++; if (bus.mem_reqstream_val !== 1'b1) begin errors++; $display("FAIL ird_mem_val: got %b expected 1", bus.mem_reqstream_val); end
    checks++; if (bus.mem_reqstream_msg.addr !== 32'h200) begin errors++; $display("FAIL ird_addr: got %h expected 00000200", bus.mem_reqstream_msg.addr); end
    checks++; if (bus.mem_reqstream_msg.opaque !== 8'h00) begin errors++; $display("FAIL ird_opaque: got %h expected 00", bus.mem_reqstream_msg.opaque); end
    checks++; if (bus.mem_reqstream_msg.type_ !== MEM_READ) begin errors++; $display("FAIL ird_type: got %h expected %h", bus.mem_reqstream_msg.type_, MEM_READ); end
    tick();
    checks++; if (bus.mem_reqstream_val !== 1'b0) begin errors++; $display("FAIL ird_mem_val_drained: got %b expected 0", bus.mem_reqstream_val); end
    bus.mem_respstream_val = 1'b1;
    bus.mem_respstream_msg = mk_resp(8'h00, 32'hdeadbeef);
    bus.imem_respstream_rdy = 1'b1; bus.dmem_respstream_rdy = 1'b1;
    #1;
    checks++; if (bus.imem_respstream_val !== 1'b1) begin errors++; $display("FAIL ird_resp_val: got %b expected 1", bus.imem_respstream_val); end
    checks++; if (bus.imem_respstream_msg.data !== 32'hdeadbeef) begin errors++; $display("FAIL ird_resp_data: got %h expected deadbeef", bus.imem_respstream_msg.data); end
    checks++; if (bus.dmem_respstream_val !== 1'b0) begin errors++; $display("FAIL ird_dmem_resp_val: got %b expected 0", bus.dmem_respstream_val); end
    checks++; if (bus.mem_respstream_rdy !== 1'b1) begin errors++; $display("FAIL ird_resp_rdy: got %b expected 1", bus.mem_respstream_rdy); end
    tick();
    idle();
  endtask

  task automatic test_dmem_write();
    do_reset();
    bus.mem_reqstream_rdy = 1'b1;
    bus.dmem_reqstream_val = 1'b1;
    bus.dmem_reqstream_msg = mk_req(MEM_WRITE, 8'h00, 32'h1000, 32'h5);
    #1;
    checks++; if (bus.dmem_reqstream_rdy !== 1'b1) begin errors++; $display("FAIL dwr_dmem_rdy: got %b expected 1", bus.dmem_reqstream_rdy); end
    checks++; if (bus.imem_reqstream_rdy !== 1'b0) begin errors++; $display("FAIL dwr_imem_rdy: got %b expected 0", bus.imem_reqstream_rdy); end
    tick();
    bus.dmem_reqstream_val = 1'b0;
    #1;
    checks++; if (bus.mem_reqstream_msg.opaque !== 8'h80) begin errors++; $display("FAIL dwr_opaque: got %h expected 80", bus.mem_reqstream_msg.opaque); end
    checks++; if (bus.mem_reqstream_msg.type_ !== MEM_WRITE) begin errors++; $display("FAIL dwr_type: got %h expected %h", bus.mem_reqstream_msg.type_, MEM_WRITE); end
    checks++; if (bus.mem_reqstream_msg.addr !== 32'h1000) begin errors++; $display("FAIL dwr_addr: got %h expected 00001000", bus.mem_reqstream_msg.addr); end
    checks++; if (bus.mem_reqstream_msg.data !== 32'h5) begin errors++; $display("FAIL dwr_data: got %h expected 00000005", bus.mem_reqstream_msg.data); end
    tick();
    bus.mem_respstream_val = 1'b1;
    bus.mem_respstream_msg = mk_resp(8'h80, 32'h0);
    bus.imem_respstream_rdy = 1'b1; bus.dmem_respstream_rdy = 1'b0;
    #1;
    checks++; if (bus.dmem_respstream_val !== 1'b1) begin errors++; $display("FAIL dwr_resp_val: got %b expected 1", bus.dmem_respstream_val); end
    checks++; if (bus.imem_respstream_val !== 1'b0) begin errors++; $display("FAIL dwr_imem_resp_val: got %b expected 0", bus.imem_respstream_val); end
    checks++; if (bus.mem_respstream_rdy !== 1'b0) begin errors++; $display("FAIL dwr_resp_rdy_low: got %b expected 0", bus.mem_respstream_rdy); end
    bus.dmem_respstream_rdy = 1'b1;
    #1;
    checks++; if (bus.mem_respstream_rdy !== 1'b1) begin errors++; $display("FAIL dwr_resp_rdy_high: got %b expected 1", bus.mem_respstream_rdy); end
    checks++; if (bus.dmem_respstream_msg.opaque !== 8'h00) begin errors++; $display("FAIL dwr_resp_opaque: got %h expected 00", bus.dmem_respstream_msg.opaque); end
    tick();
    bus.mem_respstream_val = 1'b0;
    // low opaque bits must pass untouched in both directions
    bus.dmem_reqstream_val = 1'b1;
    bus.dmem_reqstream_msg = mk_req(MEM_WRITE, 8'h15, 32'h1004, 32'h9);
    tick();
    bus.dmem_reqstream_val = 1'b0;
    #1;
    checks++; if (bus.mem_reqstream_msg.opaque !== 8'h95) begin errors++; $display("FAIL dwr_opaque_low: got %h expected 95", bus.mem_reqstream_msg.opaque); end
    tick();
    bus.mem_respstream_val = 1'b1;
    bus.mem_respstream_msg = mk_resp(8'h95, 32'h77);
    #1;
    checks++; if (bus.dmem_respstream_msg.opaque !== 8'h15) begin errors++; $display("FAIL dwr_resp_opaque_low: got %h expected 15", bus.dmem_respstream_msg.opaque); end
    checks++; if (bus.dmem_respstream_msg.data !== 32'h77) begin errors++; $display("FAIL dwr_resp_data: got %h expected 00000077", bus.dmem_respstream_msg.data); end
    tick();
    idle();
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_i;
    logic [31:0] prev_addr;
    int ni;
    int nd;
    exp_i = 4'b0101;
    prev_addr = '0;
    ni = 0;
    nd = 0;
    do_reset();
    bus.mem_reqstream_rdy = 1'b1;
    bus.imem_reqstream_val = 1'b1;
    bus.dmem_reqstream_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.imem_reqstream_msg = mk_req(MEM_READ, 8'h00, 32'h100 + k, 32'h0);
      bus.dmem_reqstream_msg = mk_req(MEM_WRITE, 8'h00, 32'h200 + k, 32'h0);
      #1;
      checks++; if (bus.imem_reqstream_rdy !== exp_i[k]) begin errors++; $display("FAIL rr_imem_rdy[%0d]: got %b expected %b", k, bus.imem_reqstream_rdy, exp_i[k]); end
      checks++; if (bus.dmem_reqstream_rdy !== !exp_i[k]) begin errors++; $display("FAIL rr_dmem_rdy[%0d]: got %b expected %b", k, bus.dmem_reqstream_rdy, !exp_i[k]); end
      if (k > 0) begin
        checks++; if (bus.mem_reqstream_msg.addr !== prev_addr) begin errors++; $display("FAIL rr_addr[%0d]: got %h expected %h", k, bus.mem_reqstream_msg.addr, prev_addr); end
      end
      if (bus.imem_reqstream_rdy === 1'b1) ni++;
      if (bus.dmem_reqstream_rdy === 1'b1) nd++;
      prev_addr = exp_i[k] ? (32'h100 + k) : (32'h200 + k);
      tick();
    end
    bus.imem_reqstream_val = 1'b0;
    bus.dmem_reqstream_val = 1'b0;
    #1;
    checks++; if (bus.mem_reqstream_msg.addr !== prev_addr) begin errors++; $display("FAIL rr_last_addr: got %h expected %h", bus.mem_reqstream_msg.addr, prev_addr); end
    checks++; if (bus.mem_reqstream_msg.opaque !== 8'h80) begin errors++; $display("FAIL rr_last_opaque: got %h expected 80", bus.mem_reqstream_msg.opaque); end
    checks++; if (ni !== 2) begin errors++; $display("FAIL rr_imem_grants: got %0d expected 2", ni); end
    checks++; if (nd !== 2) begin errors++; $display("FAIL rr_dmem_grants: got %0d expected 2", nd); end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.mem_reqstream_rdy = 1'b0;
    bus.imem_reqstream_val = 1'b1;
    bus.imem_reqstream_msg = mk_req(MEM_READ, 8'h00, 32'h300, 32'h0);
    tick();
    bus.imem_reqstream_msg = mk_req(MEM_READ, 8'h00, 32'h304, 32'h0);
    bus.dmem_reqstream_val = 1'b1;
    bus.dmem_reqstream_msg = mk_req(MEM_WRITE, 8'h00, 32'h400, 32'h1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.mem_reqstream_val !== 1'b1) begin errors++; $display("FAIL bp_mem_val[%0d]: got %b expected 1", k, bus.mem_reqstream_val); end
      checks++; if (bus.mem_reqstream_msg.addr !== 32'h300) begin errors++; $display("FAIL bp_addr[%0d]: got %h expected 00000300", k, bus.mem_reqstream_msg.addr); end
      checks++; if (bus.imem_reqstream_rdy !== 1'b0) begin errors++; $display("FAIL bp_imem_rdy[%0d]: got %b expected 0", k, bus.imem_reqstream_rdy); end
      checks++; if (bus.dmem_reqstream_rdy !== 1'b0) begin errors++; $display("FAIL bp_dmem_rdy[%0d]: got %b expected 0", k, bus.dmem_reqstream_rdy); end
      tick();
    end
    bus.mem_reqstream_rdy = 1'b1;
    #1;
    checks++; if (bus.dmem_reqstream_rdy !== 1'b1) begin errors++; $display("FAIL b2b_dmem_rdy: got %b expected 1", bus.dmem_reqstream_rdy); end
    checks++; if (bus.imem_reqstream_rdy !== 1'b0) begin errors++; $display("FAIL b2b_imem_rdy: got %b expected 0", bus.imem_reqstream_rdy); end
    tick();
    bus.dmem_reqstream_val = 1'b0;
    #1;
    checks++; if (bus.mem_reqstream_val !== 1'b1) begin errors++; $display("FAIL b2b_mem_val: got %b expected 1", bus.mem_reqstream_val); end
    checks++; if (bus.mem_reqstream_msg.addr !== 32'h400) begin errors++; $display("FAIL b2b_addr: got %h expected 00000400", bus.mem_reqstream_msg.addr); end
    checks++; if (bus.mem_reqstream_msg.opaque !== 8'h80) begin errors++; $display("FAIL b2b_opaque: got %h expected 80", bus.mem_reqstream_msg.opaque); end
    checks++; if (bus.imem_reqstream_rdy !== 1'b1) begin errors++; $display("FAIL b2b_imem_rdy_full: got %b expected 1", bus.imem_reqstream_rdy); end
    idle();
  endtask

  task automatic test_inflight_limit();
    int nx;
    do_reset();
    lim.mem_reqstream_rdy = 1'b1;
    lim.imem_reqstream_val = 1'b1;
    lim.imem_reqstream_msg = mk_req(MEM_READ, 8'h00, 32'h600, 32'h0);
    nx = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (lim.mem_reqstream_val === 1'b1 && lim.mem_reqstream_rdy === 1'b1) nx++;
      tick();
    end
    #1;
    checks++; if (nx !== 2) begin errors++; $display("FAIL lim_issued: got %0d expected 2", nx); end
    checks++; if (lim.mem_reqstream_val !== 1'b0) begin errors++; $display("FAIL lim_mem_val: got %b expected 0", lim.mem_reqstream_val); end
    checks++; if (lim.imem_reqstream_rdy !== 1'b0) begin errors++; $display("FAIL lim_imem_rdy: got %b expected 0", lim.imem_reqstream_rdy); end
    lim.mem_respstream_val = 1'b1;
    lim.mem_respstream_msg = mk_resp(8'h00, 32'h11);
    lim.imem_respstream_rdy = 1'b1;
    #1;
    checks++; if (lim.mem_respstream_rdy !== 1'b1) begin errors++; $display("FAIL lim_resp_rdy: got %b expected 1", lim.mem_respstream_rdy); end
    nx = 0;
    if (lim.mem_reqstream_val === 1'b1) nx++;
    tick();
    lim.mem_respstream_val = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (lim.mem_reqstream_val === 1'b1 && lim.mem_reqstream_rdy === 1'b1) nx++;
      tick();
    end
    checks++; if (nx !== 1) begin errors++; $display("FAIL lim_reissued: got %0d expected 1", nx); end
    idle();
  endtask

  task automatic test_reset_mid();
    int nx;
    logic [31:0] first_addr;
    do_reset();
    bus.mem_reqstream_rdy = 1'b1;
    bus.imem_reqstream_val = 1'b1;
    bus.imem_reqstream_msg = mk_req(MEM_READ, 8'h00, 32'h500, 32'h0);
    for (int k = 0; k < 4; k++) tick();
    bus.mem_reqstream_rdy = 1'b0;
    #1;
    checks++; if (bus.mem_reqstream_val !== 1'b1) begin errors++; $display("FAIL mid_full_before: got %b expected 1", bus.mem_reqstream_val); end
    reset = 1'b1;
    bus.dmem_reqstream_val = 1'b1;
    bus.dmem_reqstream_msg = mk_req(MEM_WRITE, 8'h00, 32'h580, 32'h0);
    tick();
    checks++; if (bus.mem_reqstream_val !== 1'b0) begin errors++; $display("FAIL mid_in_rst_val: got %b expected 0", bus.mem_reqstream_val); end
    reset = 1'b0;
    bus.imem_reqstream_msg = mk_req(MEM_READ, 8'h00, 32'h700, 32'h0);
    bus.mem_reqstream_rdy = 1'b1;
    #1;
    checks++; if (bus.mem_reqstream_val !== 1'b0) begin errors++; $display("FAIL mid_buf_cleared: got %b expected 0", bus.mem_reqstream_val); end
    checks++; if (bus.imem_reqstream_rdy !== 1'b1) begin errors++; $display("FAIL mid_prio_imem: got %b expected 1", bus.imem_reqstream_rdy); end
    checks++; if (bus.dmem_reqstream_rdy !== 1'b0) begin errors++; $display("FAIL mid_prio_dmem: got %b expected 0", bus.dmem_reqstream_rdy); end
    tick();
    bus.dmem_reqstream_val = 1'b0;
    nx = 0;
    first_addr = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (bus.mem_reqstream_val === 1'b1 && bus.mem_reqstream_rdy === 1'b1) begin
        if (nx == 0) first_addr = bus.mem_reqstream_msg.addr;
        nx++;
      end
      tick();
    end
    checks++; if (nx !== 4) begin errors++; $display("FAIL mid_count_cleared: got %0d expected 4", nx); end
    checks++; if (first_addr !== 32'h700) begin errors++; $display("FAIL mid_first_addr: got %h expected 00000700", first_addr); end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_imem_read();
    test_dmem_write();
    test_round_robin();
    test_back_to_back();
    test_inflight_limit();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
